// File: rtl/kernel_harness_pkg.sv
// Shared types and sizing helpers for the kernel memory harness.
package kernel_harness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Counter width that holds the largest of the three limits without overflow.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/harness_read_drain.sv
// Result readback: one outstanding RAM read at a time feeding a single-entry
// output register with backpressure and last-word marking.
module harness_read_drain
    import kernel_harness_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RESULT_BASE  = 0,
    parameter int RESULT_COUNT = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] RB      = ADDR_W'(RESULT_BASE);
    localparam logic [CNT_W-1:0]  RC      = CNT_W'(RESULT_COUNT);
    localparam logic [CNT_W-1:0]  RC_LAST = CNT_W'(RESULT_COUNT - 1);

    logic [CNT_W-1:0]  iss_q, iss_d;
    logic              pend_q, pend_d;
    logic              plast_q, plast_d;
    logic              oval_q, oval_d;
    logic              olast_q, olast_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              issue;

    // A new read only goes out when its data is guaranteed a free output slot.
    assign issue = active_i && !pend_q && (!oval_q || out_ready_i) && (iss_q != RC);

    assign ram_raddr_o = issue ? RB + ADDR_W'(iss_q) : '0;
    assign out_valid_o = oval_q;
    assign out_data_o  = odata_q;
    assign out_last_o  = olast_q;
    assign done_o      = active_i && oval_q && out_ready_i && olast_q;

    always_comb begin
        iss_d   = iss_q;
        pend_d  = pend_q;
        plast_d = plast_q;
        oval_d  = oval_q;
        olast_d = olast_q;
        odata_d = odata_q;
        if (!active_i) begin
            iss_d   = '0;
            pend_d  = 1'b0;
            plast_d = 1'b0;
            oval_d  = 1'b0;
            olast_d = 1'b0;
        end else begin
            if (oval_q && out_ready_i) begin
                oval_d  = 1'b0;
                olast_d = 1'b0;
            end
            if (pend_q) begin
                odata_d = ram_rdata_i;
                oval_d  = 1'b1;
                olast_d = plast_q;
                pend_d  = 1'b0;
            end
            if (issue) begin
                pend_d  = 1'b1;
                plast_d = (iss_q == RC_LAST);
                iss_d   = iss_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q   <= '0;
            pend_q  <= 1'b0;
            plast_q <= 1'b0;
            oval_q  <= 1'b0;
            olast_q <= 1'b0;
            odata_q <= '0;
        end else begin
            iss_q   <= iss_d;
            pend_q  <= pend_d;
            plast_q <= plast_d;
            oval_q  <= oval_d;
            olast_q <= olast_d;
            odata_q <= odata_d;
        end
    end

endmodule

// File: rtl/kernel_mem_harness.sv
// Sequences one HLS kernel job: stream-load the RAM, run the kernel, stream
// the results back out. Owns RAM port 0 except while the kernel runs.
module kernel_mem_harness
    import kernel_harness_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LOAD_BASE    = 10,
    parameter int LOAD_COUNT   = 2,
    parameter int RESULT_BASE  = 0,
    parameter int RESULT_COUNT = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              k_rst,
    input  logic              k_valid,
    input  logic [ADDR_W-1:0] k_waddr,
    input  logic [DATA_W-1:0] k_wdata,
    input  logic              k_wen,
    input  logic [ADDR_W-1:0] k_raddr,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = cnt_width(LOAD_COUNT, RESULT_COUNT, TIMEOUT);
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_COUNT - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LB        = ADDR_W'(LOAD_BASE);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic [ADDR_W-1:0] drain_raddr;
    logic              drain_done;

    assign in_ready    = (state_q == LOAD);
    assign k_rst       = (state_q != RUN);
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

    // cnt_q counts accepted words in LOAD and elapsed cycles in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    state_d = LOAD;
                    terr_d  = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (k_valid) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_wen   = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    ram_wen   = 1'b1;
                    ram_waddr = LB + ADDR_W'(cnt_q);
                    ram_wdata = in_data;
                end
            end
            RUN: begin
                ram_wen   = k_wen;
                ram_waddr = k_waddr;
                ram_wdata = k_wdata;
                ram_raddr = k_raddr;
            end
            DRAIN: ram_raddr = drain_raddr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    harness_read_drain #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RESULT_BASE (RESULT_BASE),
        .RESULT_COUNT(RESULT_COUNT),
        .CNT_W       (CNT_W)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .active_i   (state_q == DRAIN),
        .ram_rdata_i(ram_rdata),
        .out_ready_i(out_ready),
        .ram_raddr_o(drain_raddr),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .done_o     (drain_done)
    );

endmodule

// File: tb/tb_kernel_mem_harness.sv
// Directed bench: harness driving a RAM model with a loop_add_7 kernel stub,
// plus a second instance exercising load-address wrap.
module tb_kernel_mem_harness;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_data, out_data;
    logic [4:0]  ram_waddr, ram_raddr, k_waddr, k_raddr;
    logic [31:0] ram_wdata, ram_rdata, k_wdata;
    logic        ram_wen, k_rst, k_valid, k_wen, busy, timeout_err;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_last, w_ram_wen;
    logic        w_k_rst, w_busy, w_timeout_err;
    logic [31:0] w_in_data, w_out_data, w_ram_wdata;
    logic [4:0]  w_ram_waddr, w_ram_raddr;

    logic [31:0] mem [32];
    logic [1:0]  kstep;
    logic        kernel_en;
    int          wen_cnt = 0, hs_cnt = 0, ov_cnt = 0;
    int          tests = 0, fails = 0;
    int          wb, ovb;

    always #5 clk = ~clk;

    kernel_mem_harness #(.LOAD_BASE(10), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .k_rst(k_rst), .k_valid(k_valid), .k_waddr(k_waddr), .k_wdata(k_wdata),
        .k_wen(k_wen), .k_raddr(k_raddr),
        .busy(busy), .timeout_err(timeout_err)
    );

    kernel_mem_harness #(.LOAD_BASE(31)) u_wrap (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_last(w_out_last),
        .ram_waddr(w_ram_waddr), .ram_wdata(w_ram_wdata), .ram_wen(w_ram_wen),
        .ram_raddr(w_ram_raddr), .ram_rdata(32'd0),
        .k_rst(w_k_rst), .k_valid(1'b0), .k_waddr(5'd0), .k_wdata(32'd0),
        .k_wen(1'b0), .k_raddr(5'd0),
        .busy(w_busy), .timeout_err(w_timeout_err)
    );

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
        wen_cnt   <= wen_cnt + int'(ram_wen);
        hs_cnt    <= hs_cnt + int'(out_valid && out_ready);
        ov_cnt    <= ov_cnt + int'(out_valid);
    end

    // loop_add_7 stub: read 10 and 11, write value+7 to 0 and 1, then signal done.
    always @(posedge clk) begin
        if (k_rst) kstep <= 2'd0;
        else if (kstep != 2'd3) kstep <= kstep + 2'd1;
    end

    always_comb begin
        k_raddr = 5'd0;
        k_waddr = 5'd0;
        k_wdata = 32'd0;
        k_wen   = 1'b0;
        k_valid = 1'b0;
        case (kstep)
            2'd0: k_raddr = 5'd10;
            2'd1: begin
                k_raddr = 5'd11;
                k_wen   = 1'b1;
                k_waddr = 5'd0;
                k_wdata = ram_rdata + 32'd7;
            end
            2'd2: begin
                k_wen   = 1'b1;
                k_waddr = 5'd1;
                k_wdata = ram_rdata + 32'd7;
            end
            default: k_valid = kernel_en;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; kernel_en = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0;
        cyc(); cyc(); #1;
        check("rst_busy", busy, 0);
        check("rst_k_rst", k_rst, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_waddr", ram_waddr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_raddr", ram_raddr, 0);
        rst = 1'b1;

        // Job 1: load 10,5; expect 17 then 12 with backpressure on the first word
        cyc(); in_valid = 1'b1; in_data = 32'd10; #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_wen", ram_wen, 0);
        cyc(); #1;
        check("ld0_in_ready", in_ready, 1);
        check("ld0_wen", ram_wen, 1);
        check("ld0_waddr", ram_waddr, 10);
        check("ld0_wdata", ram_wdata, 10);
        check("ld0_k_rst", k_rst, 1);
        cyc(); in_data = 32'd5; #1;
        check("ld1_wen", ram_wen, 1);
        check("ld1_waddr", ram_waddr, 11);
        check("ld1_wdata", ram_wdata, 5);
        check("ld1_k_rst", k_rst, 1);
        cyc(); in_valid = 1'b0; #1;
        check("run_k_rst", k_rst, 0);
        check("run_in_ready", in_ready, 0);
        check("run_busy", busy, 1);
        check("run_raddr_mux", ram_raddr, 10);
        cyc(); #1;
        check("run_wen_mux", ram_wen, 1);
        check("run_waddr_mux", ram_waddr, 0);
        check("run_wdata_mux", ram_wdata, 17);
        cyc(); cyc(); #1;
        check("run_kvalid_k_rst", k_rst, 0);
        cyc(); #1;
        check("drain_k_rst", k_rst, 1);
        check("drain_raddr0", ram_raddr, 0);
        check("drain_wen", ram_wen, 0);
        cyc(); out_ready = 1'b0; #1;
        check("drain_pend_ov", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 17);
            check("bp_last", out_last, 0);
        end
        cyc(); out_ready = 1'b1; #1;
        check("w0_valid", out_valid, 1);
        check("w0_data", out_data, 17);
        check("drain_raddr1", ram_raddr, 1);
        cyc(); #1;
        check("gap_valid", out_valid, 0);
        cyc(); #1;
        check("w1_valid", out_valid, 1);
        check("w1_data", out_data, 12);
        check("w1_last", out_last, 1);
        cyc(); #1;
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        check("word_count", hs_cnt, 2);
        check("ram10", mem[10], 10);
        check("ram11", mem[11], 5);

        // Job 2: kernel never finishes, abort after 20 RUN cycles
        kernel_en = 1'b0;
        in_valid = 1'b1; in_data = 32'd1;
        cyc(); cyc(); in_data = 32'd2;
        cyc(); in_valid = 1'b0; ovb = ov_cnt; #1;
        check("to_run1_k_rst", k_rst, 0);
        repeat (19) cyc();
        #1;
        check("to_run20_busy", busy, 1);
        check("to_run20_k_rst", k_rst, 0);
        cyc(); #1;
        check("to_busy", busy, 0);
        check("to_terr", timeout_err, 1);
        check("to_k_rst", k_rst, 1);
        check("to_no_output", ov_cnt - ovb, 0);

        // Job 3: gapped load, clears timeout_err, then reset mid-RUN
        kernel_en = 1'b1;
        in_valid = 1'b1; in_data = 32'h100; #1;
        check("j3_idle_terr", timeout_err, 1);
        cyc(); wb = wen_cnt; #1;
        check("j3_terr_clr", timeout_err, 0);
        check("gap0_wen", ram_wen, 1);
        check("gap0_waddr", ram_waddr, 10);
        check("gap0_wdata", ram_wdata, 32'h100);
        cyc(); in_valid = 1'b0; #1;
        check("gap1_wen", ram_wen, 0);
        check("gap1_in_ready", in_ready, 1);
        cyc(); #1;
        check("gap2_wen", ram_wen, 0);
        cyc(); in_valid = 1'b1; in_data = 32'h200; #1;
        check("gap3_wen", ram_wen, 1);
        check("gap3_waddr", ram_waddr, 11);
        check("gap3_wdata", ram_wdata, 32'h200);
        cyc(); in_valid = 1'b0; #1;
        check("gap_run_k_rst", k_rst, 0);
        check("gap_write_count", wen_cnt - wb, 2);
        rst = 1'b0; #1;
        check("mr_busy", busy, 0);
        check("mr_k_rst", k_rst, 1);
        check("mr_in_ready", in_ready, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 0);
        check("mr_wen", ram_wen, 0);
        check("mr_raddr", ram_raddr, 0);
        check("mr_terr", timeout_err, 0);
        cyc(); rst = 1'b1; ovb = ov_cnt;
        repeat (8) cyc();
        #1;
        check("mr_after_busy", busy, 0);
        check("mr_after_no_output", ov_cnt - ovb, 0);

        // Wrap instance: LOAD_BASE=31 writes to 31 then 0
        w_in_valid = 1'b1; w_in_data = 32'd7;
        cyc(); #1;
        check("wrap0_wen", w_ram_wen, 1);
        check("wrap0_waddr", w_ram_waddr, 31);
        check("wrap0_wdata", w_ram_wdata, 7);
        check("wrap0_in_ready", w_in_ready, 1);
        check("wrap0_k_rst", w_k_rst, 1);
        cyc(); #1;
        check("wrap1_wen", w_ram_wen, 1);
        check("wrap1_waddr", w_ram_waddr, 0);
        cyc(); w_in_valid = 1'b0; #1;
        check("wrap_run_wen", w_ram_wen, 0);
        check("wrap_run_busy", w_busy, 1);
        check("wrap_run_raddr", w_ram_raddr, 0);
        check("wrap_out_valid", w_out_valid, 0);
        check("wrap_out_last", w_out_last, 0);
        check("wrap_out_data", w_out_data, 0);
        check("wrap_terr", w_timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kernel_mem_harness.md
Name: kernel_mem_harness

Overview:
- Controller that sits between the host stream and the two-read/one-write kernel RAM, and wraps one HLS kernel such as loop_add_7.
- Sequence: stream input words into the RAM, release the kernel from reset, wait for kernel valid, then read result words back out of the RAM as an output stream.
- Owns RAM write port 0 and read port 0 outside the kernel's run window. Forwards the kernel's port signals inside that window.

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 32, RAM data width
- LOAD_BASE, 10, first RAM address written from the input stream
- LOAD_COUNT, 2, number of input words per job (1..2^ADDR_W)
- RESULT_BASE, 0, first RAM address read back
- RESULT_COUNT, 2, number of result words per job (1..2^ADDR_W)
- TIMEOUT, 1023, maximum RUN cycles before abort

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  input word valid
- in_ready  out  1  harness accepts input word
- in_data  in  DATA_W  input word
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts result word
- out_data  out  DATA_W  result word
- out_last  out  1  marks final result word of the job
- ram_waddr / ram_wdata / ram_wen  out  ADDR_W / DATA_W / 1  RAM write port 0
- ram_raddr  out  ADDR_W  RAM read port 0 address
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_raddr
- k_rst  out  1  kernel reset, active-high
- k_valid  in  1  kernel done
- k_waddr / k_wdata / k_wen / k_raddr  in  matching widths  kernel RAM requests
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset values (rst=0):
  - state=IDLE; k_rst=1; ram_wen=0; ram_waddr/ram_raddr/ram_wdata=0.
  - in_ready=0; out_valid=0; out_last=0; out_data=0; busy=0; timeout_err=0; all counters=0.
- Reset taking effect mid-job abandons the job immediately. No partial output completes after rst returns to 1.
- States: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
- IDLE:
  - in_ready=0; k_rst=1.
  - Moves to LOAD on the first cycle in_valid=1. The word is not consumed in that cycle.
  - timeout_err clears on this transition.
- LOAD:
  - in_ready=1; k_rst=1.
  - On each in_valid&&in_ready: ram_wen=1, ram_waddr=LOAD_BASE+cnt (mod 2^ADDR_W, wraps), ram_wdata=in_data, cnt++.
  - Write port outputs are combinational from the handshake.
  - After word LOAD_COUNT-1 is accepted, the next state is RUN and in_ready drops in the following cycle.
- RUN:
  - k_rst=0 from the first RUN cycle.
  - ram_waddr/ram_wdata/ram_wen/ram_raddr equal k_waddr/k_wdata/k_wen/k_raddr (combinational mux).
  - Cycle counter increments each RUN cycle.
  - k_valid=1 -> DRAIN next cycle, with k_rst=1 reasserted in that cycle.
  - Counter reaching TIMEOUT without k_valid -> set timeout_err, k_rst=1, go to IDLE. No output is produced.
- DRAIN:
  - ram_wen=0.
  - One outstanding read at a time. Issue ram_raddr=RESULT_BASE+idx (wraps) when no read is pending and the output register is empty or being emptied this cycle.
  - The cycle after issue, capture ram_rdata into out_data and set out_valid=1. out_last=1 when idx==RESULT_COUNT-1.
  - out_data/out_valid/out_last are held stable while out_valid&&!out_ready.
  - Throughput: one word per 2 cycles with out_ready held high.
  - After the last word handshakes -> IDLE.
- Simultaneous in_valid in DRAIN or RUN is ignored (in_ready=0). A new job starts only from IDLE.
- Counters are wide enough for LOAD_COUNT, RESULT_COUNT and TIMEOUT with no overflow.

Decomposition:
- Shared package kernel_harness_pkg: state enum (IDLE, LOAD, RUN, DRAIN); default ADDR_W/DATA_W localparams.
- One natural sub-module, harness_read_drain: read issue, one-cycle data capture, output register with backpressure and out_last generation.
- FSM, load path and port mux stay in the top level.

Test Plan:
- Load 10,5 with loop_add_7 behind the harness -> RAM[10]=10, RAM[11]=5 written; k_rst falls one cycle after the second accept; after k_valid, out stream is 17 then 12; out_last on 12.
- out_ready low for 3 cycles while the first result is valid -> out_data holds 17 unchanged; 12 follows only after the 17 handshake; exactly 2 words are emitted.
- Kernel stub never asserts k_valid, TIMEOUT=20 -> after 20 RUN cycles timeout_err=1, state IDLE, out_valid never 1; the next job clears timeout_err.
- LOAD_BASE=31, LOAD_COUNT=2 -> writes land at addresses 31 then 0 (wrap).
- rst driven 0 during RUN, then released -> all outputs at reset values; busy=0; k_rst=1; no out_valid until a new job.
- Gapped in_valid (1,0,0,1) in LOAD -> exactly 2 writes at LOAD_BASE and LOAD_BASE+1; ram_wen only in the handshake cycles.
